ppu_fetch_unit: RTL and testbench
=================================

# ppu_fetch_unit

Instruction fetch stage of the PPU pipeline: the producer end of the instruction interface that the ID-stage control unit decodes. It generates the PC and issues word requests to a synchronous-read instruction memory. Returned words are buffered in a 2-entry queue and presented to ID with a valid/ready handshake. It accepts branch/jump redirects from ID, squashes stale fetches, and restarts at the target.

## Interface
Parameters:
- ADDR_W, 9: instruction memory byte-address width; `imem_addr = fetch_pc[ADDR_W-1:0]`.
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_W  byte address of requested word.
- imem_rdata  in  32  instruction word, valid exactly one cycle after `imem_req`.
- id_instr  out  32  instruction at queue head.
- id_pc  out  32  PC of `id_instr`.
- id_valid  out  1  queue head holds a valid instruction.
- id_ready  in  1  ID consumes the head when `id_valid & id_ready`.
- redirect  in  1  one-cycle pulse from ID (taken branch or jump).
- redirect_target  in  32  new fetch PC, sampled when `redirect` = 1.
- fetch_misalign  out  1  sticky misaligned-target flag (see Configuration).

## Operation
- State:
  - fetch_pc (32 b)
  - inflight bit plus inflight_pc and inflight_epoch
  - epoch bit
  - 2-entry FIFO of {pc, instr}: head/tail pointers, 2-bit count
- Reset values:
  - fetch_pc = RESET_PC
  - imem_req = 0; imem_addr = RESET_PC[ADDR_W-1:0]
  - FIFO empty; id_valid = 0; id_instr = 0; id_pc = 0
  - inflight = 0; epoch = 0; fetch_misalign = 0
- Issue rule (no redirect): `imem_req = ((count + inflight - pop) < 2)`, where `pop = id_valid & id_ready`. On issue, the inflight pc/epoch are captured and fetch_pc advances by 4.
- PC arithmetic: 32-bit, modulo 2^32; 32'hFFFF_FFFC + 4 = 0. imem_addr truncates silently.
- Response: the cycle after an issue, the entry {inflight_pc, imem_rdata} is written at tail if inflight_epoch == epoch; otherwise it is discarded.
- Push and pop in the same cycle: count unchanged. The queue can never overflow because of the issue rule.
- Redirect (highest priority after reset):
  - FIFO flushed.
  - epoch toggled, so any inflight response is discarded.
  - imem_req = 1 with imem_addr = target in the same cycle.
  - fetch_pc = target + 4.
- A handshake at the head completing in the redirect cycle is honoured. ID consumes that instruction (delay slot); the rest is squashed.
- Back-to-back redirects: each one flushes and retargets; only the last target survives.

## Timing
- First instruction after reset release: req in cycle 0, id_valid = 1 in cycle 2.
- Redirect in cycle N: id_valid = 0 in N+1; target instruction has id_valid = 1 in N+2.
- Throughput: 1 instruction/cycle with id_ready held high.
- Backpressure: with id_ready = 0 the FIFO fills to 2 and imem_req drops. Issuing resumes the cycle a pop occurs.
- id_instr and id_pc are stable while `id_valid & !id_ready`.
- Reset asserted mid-operation: everything clears asynchronously; the pending memory response is ignored.

## Configuration
- `PPU_FETCH_ALIGN_CHECK_EN` defined:
  - a redirect with target[1:0] != 0 sets fetch_misalign (cleared only by reset);
  - fetch proceeds from {target[31:2], 2'b00}.
- Not defined:
  - target[1:0] forced to 00 silently;
  - fetch_misalign tied 0.

## Test plan
- Reset release, memory word at addr = addr, id_ready = 1 → id_pc 0,4,8,C… on consecutive cycles from cycle 2; instr matches.
- id_ready low for 5 cycles after first valid → count saturates at 2, imem_req = 0, id_pc holds 0. On release, the sequence continues 0,4,8 with no gap or duplicate.
- Redirect to 32'h40 while one response is in flight and FIFO holds 2 → stale words never appear; id_pc = 0x40 two cycles later, then 0x44.
- Redirect in the same cycle as a head handshake at pc 0x10 → 0x10 consumed once; next id_pc = target.
- Redirect to 32'h42 with macro defined → fetch_misalign = 1 and id_pc = 0x40. Without macro → fetch_misalign stays 0.
- PC at 32'hFFFF_FFFC → next id_pc = 0. Reset asserted mid-stream → id_valid = 0 immediately and restart at RESET_PC.

Source files
------------

// File: rtl/ppu_fetch_if.sv
// ppu_fetch_if: instruction-memory and ID-stage handshake bundle of the PPU fetch unit.
interface ppu_fetch_if #(parameter int ADDR_W = 9);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic [31:0]       id_instr;
   logic [31:0]       id_pc;
   logic              id_valid;
   logic              id_ready;
   logic              redirect;
   logic [31:0]       redirect_target;
   logic              fetch_misalign;
   modport master (
      output imem_req, imem_addr, id_instr, id_pc, id_valid, fetch_misalign,
      input  imem_rdata, id_ready, redirect, redirect_target
   );
   modport slave (
      input  imem_req, imem_addr, id_instr, id_pc, id_valid, fetch_misalign,
      output imem_rdata, id_ready, redirect, redirect_target
   );
endinterface

// File: rtl/ppu_fetch_unit.sv
// ppu_fetch_unit: PC generation, synchronous imem requests, 2-entry instruction queue, redirect squash.
// Optional macro PPU_FETCH_ALIGN_CHECK_EN enables the sticky misaligned-redirect flag.
module ppu_fetch_unit #(
   parameter int          ADDR_W   = 9,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic        clk,
   input logic        reset,
   ppu_fetch_if.master bus
);
   logic [31:0] fetch_pc, inflight_pc, tgt;
   logic [31:0] q_pc [2];
   logic [31:0] q_instr [2];
   logic        inflight, inflight_epoch, epoch, head, tail, pop, push, misalign;
   logic [1:0]  count;
   assign tgt           = {bus.redirect_target[31:2], 2'b00};
   assign pop           = bus.id_valid & bus.id_ready;
   // Responses issued before the last redirect carry the old epoch and are dropped.
   assign push          = inflight & (inflight_epoch == epoch);
   assign bus.id_valid  = count != 2'd0;
   assign bus.id_pc     = q_pc[head];
   assign bus.id_instr  = q_instr[head];
   assign bus.imem_req  = !reset & (bus.redirect |
                          (({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2));
   assign bus.imem_addr = bus.redirect ? tgt[ADDR_W-1:0] : fetch_pc[ADDR_W-1:0];
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc       <= RESET_PC;
         inflight       <= 1'b0;
         inflight_pc    <= '0;
         inflight_epoch <= 1'b0;
         epoch          <= 1'b0;
         head           <= 1'b0;
         tail           <= 1'b0;
         count          <= '0;
         q_pc           <= '{default: '0};
         q_instr        <= '{default: '0};
      end else if (bus.redirect) begin
         epoch          <= ~epoch;
         inflight       <= 1'b1;
         inflight_pc    <= tgt;
         inflight_epoch <= ~epoch;
         fetch_pc       <= tgt + 32'd4;
         head           <= 1'b0;
         tail           <= 1'b0;
         count          <= '0;
      end else begin
         if (push) begin
            q_pc[tail]    <= inflight_pc;
            q_instr[tail] <= bus.imem_rdata;
            tail          <= ~tail;
         end
         if (pop) head <= ~head;
         count    <= count + {1'b0, push} - {1'b0, pop};
         inflight <= bus.imem_req;
         if (bus.imem_req) begin
            inflight_pc    <= fetch_pc;
            inflight_epoch <= epoch;
            fetch_pc       <= fetch_pc + 32'd4;
         end
      end
   end
`ifdef PPU_FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) misalign <= 1'b0;
      else if (bus.redirect && bus.redirect_target[1:0] != 2'b00) misalign <= 1'b1;
   end
`else
   assign misalign = &{1'b0, bus.redirect_target[1:0]};
`endif
   assign bus.fetch_misalign = misalign;
endmodule

// File: tb/tb_ppu_fetch_unit.sv
// tb_ppu_fetch_unit: scoreboard bench for ppu_fetch_unit; memory word at address a is 32'hA500_0000 | a.
module tb_ppu_fetch_unit;
   logic        clk = 1'b0;
   logic        reset;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] sb [$];
   logic [31:0] exp_pc;
   logic        exp_mis;
   ppu_fetch_if #(.ADDR_W(9)) bus ();
   ppu_fetch_unit #(.ADDR_W(9), .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [31:0] word(input logic [8:0] a);
      return 32'hA500_0000 | {23'd0, a};
   endfunction
   always @(posedge clk) if (bus.imem_req) bus.imem_rdata <= word(bus.imem_addr);
   always @(negedge clk) begin
      if (!reset && bus.id_valid && bus.id_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got id_pc=%h, required no handshake", bus.id_pc);
         end else begin
            exp_pc = sb.pop_front();
            if (bus.id_pc !== exp_pc || bus.id_instr !== word(exp_pc[8:0])) begin
               failures++;
               $display("FAIL sb_handshake: got pc=%h instr=%h, required pc=%h instr=%h",
                        bus.id_pc, bus.id_instr, exp_pc, word(exp_pc[8:0]));
            end
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drain(input string name);
      for (int n = 0; n < 20; n++) begin
         tick();
         if (sb.size() == 0) break;
      end
      bus.id_ready = 1'b0;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL %s_drain: got %0d pending, required 0", name, sb.size());
         sb.delete();
      end
   endtask
   task automatic test_reset();
      reset = 1'b1;
      bus.id_ready = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_target = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b, required 0", bus.id_valid); end
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b, required 0", bus.imem_req); end
      checks++; if (bus.imem_addr !== 9'h0) begin failures++; $display("FAIL rst_addr: got %h, required 0", bus.imem_addr); end
      checks++; if (bus.id_pc !== 32'h0 || bus.id_instr !== 32'h0) begin failures++; $display("FAIL rst_head: got pc=%h instr=%h, required 0/0", bus.id_pc, bus.id_instr); end
      checks++; if (bus.fetch_misalign !== 1'b0) begin failures++; $display("FAIL rst_misalign: got %b, required 0", bus.fetch_misalign); end
   endtask
   task automatic test_stream();
      for (int i = 0; i < 8; i++) sb.push_back(32'(i * 4));
      bus.id_ready = 1'b1;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h0) begin failures++; $display("FAIL stream_c0_req: got req=%b addr=%h, required 1/000", bus.imem_req, bus.imem_addr); end
      tick();
      @(negedge clk);
      checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL stream_c1_valid: got %b, required 0", bus.id_valid); end
      tick();
      @(negedge clk);
      checks++; if (bus.id_valid !== 1'b1) begin failures++; $display("FAIL stream_c2_valid: got %b, required 1", bus.id_valid); end
      drain("stream");
   endtask
   task automatic test_backpressure();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h20 || bus.id_instr !== word(9'h20)) begin failures++; $display("FAIL bp_hold: got valid=%b pc=%h instr=%h, required 1/00000020/%h", bus.id_valid, bus.id_pc, bus.id_instr, word(9'h20)); end
         checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL bp_req: got %b, required 0", bus.imem_req); end
         tick();
      end
      for (int i = 0; i < 6; i++) sb.push_back(32'h20 + 32'(i * 4));
      bus.id_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL bp_resume_req: got %b, required 1", bus.imem_req); end
      drain("bp");
   endtask
   task automatic test_redirect_stale();
      bus.redirect = 1'b1;
      bus.redirect_target = 32'h40;
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h40) begin failures++; $display("FAIL stale_req: got req=%b addr=%h, required 1/040", bus.imem_req, bus.imem_addr); end
      tick();
      bus.redirect = 1'b0;
      @(negedge clk);
      checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL stale_n1_valid: got %b, required 0", bus.id_valid); end
      tick();
      sb.push_back(32'h40);
      sb.push_back(32'h44);
      bus.id_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.id_valid !== 1'b1) begin failures++; $display("FAIL stale_n2_valid: got %b, required 1", bus.id_valid); end
      drain("stale");
   endtask
   task automatic test_redirect_handshake();
      sb.push_back(32'h48);
      sb.push_back(32'h100);
      sb.push_back(32'h104);
      bus.id_ready = 1'b1;
      bus.redirect = 1'b1;
      bus.redirect_target = 32'h100;
      @(negedge clk);
      checks++; if (bus.id_valid !== 1'b1) begin failures++; $display("FAIL hs_slot_valid: got %b, required 1", bus.id_valid); end
      tick();
      bus.redirect = 1'b0;
      @(negedge clk);
      checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL hs_n1_valid: got %b, required 0", bus.id_valid); end
      drain("hs");
   endtask
   task automatic test_back_to_back();
      bus.redirect = 1'b1;
      bus.redirect_target = 32'h200;
      tick();
      bus.redirect_target = 32'h300;
      @(negedge clk);
      checks++; if (bus.imem_addr !== 9'h100) begin failures++; $display("FAIL b2b_addr: got %h, required 100", bus.imem_addr); end
      tick();
      bus.redirect = 1'b0;
      @(negedge clk);
      checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL b2b_n1_valid: got %b, required 0", bus.id_valid); end
      tick();
      sb.push_back(32'h300);
      sb.push_back(32'h304);
      bus.id_ready = 1'b1;
      drain("b2b");
   endtask
   task automatic test_wrap();
      bus.redirect = 1'b1;
      bus.redirect_target = 32'hFFFF_FFF8;
      tick();
      bus.redirect = 1'b0;
      tick();
      sb.push_back(32'hFFFF_FFF8);
      sb.push_back(32'hFFFF_FFFC);
      sb.push_back(32'h0);
      sb.push_back(32'h4);
      bus.id_ready = 1'b1;
      drain("wrap");
   endtask
   task automatic test_misalign();
`ifdef PPU_FETCH_ALIGN_CHECK_EN
      exp_mis = 1'b1;
`else
      exp_mis = 1'b0;
`endif
      bus.redirect = 1'b1;
      bus.redirect_target = 32'h42;
      @(negedge clk);
      checks++; if (bus.imem_addr !== 9'h40) begin failures++; $display("FAIL mis_addr: got %h, required 040", bus.imem_addr); end
      tick();
      bus.redirect = 1'b0;
      @(negedge clk);
      checks++; if (bus.fetch_misalign !== exp_mis) begin failures++; $display("FAIL mis_flag: got %b, required %b", bus.fetch_misalign, exp_mis); end
      tick();
      sb.push_back(32'h40);
      sb.push_back(32'h44);
      bus.id_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.id_pc !== 32'h40) begin failures++; $display("FAIL mis_pc: got %h, required 00000040", bus.id_pc); end
      drain("mis");
      checks++; if (bus.fetch_misalign !== exp_mis) begin failures++; $display("FAIL mis_sticky: got %b, required %b", bus.fetch_misalign, exp_mis); end
   endtask
   task automatic test_reset_midstream();
      sb.push_back(32'h48);
      sb.push_back(32'h4C);
      bus.id_ready = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      #1;
      checks++; if (bus.id_valid !== 1'b0 || bus.imem_req !== 1'b0) begin failures++; $display("FAIL mid_rst: got valid=%b req=%b, required 0/0", bus.id_valid, bus.imem_req); end
      checks++; if (bus.id_pc !== 32'h0 || bus.fetch_misalign !== 1'b0) begin failures++; $display("FAIL mid_rst_state: got pc=%h mis=%b, required 0/0", bus.id_pc, bus.fetch_misalign); end
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL mid_pre_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
      tick();
      sb.push_back(32'h0);
      sb.push_back(32'h4);
      sb.push_back(32'h8);
      reset = 1'b0;
      drain("mid");
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_stale();
      test_redirect_handshake();
      test_back_to_back();
      test_wrap();
      test_misalign();
      test_reset_midstream();
      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
